alu_mc: RTL

//  Parametrised multi-cycle integer execute unit: RV32I ALU ops in 1 cycle plus RV32M
//  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU via iterative shift-add / restoring divide.

---
 rtl/alu_mc.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle integer execute unit: single-cycle RV32I ALU ops plus iterative RV32M
// multiply (shift-add) and divide (restoring), with valid/ready on both sides.
module alu_mc #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [3:0]      field,
    input  logic            m_ext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_t;

    state_t            state;
    logic [XLEN-1:0]   hi;   // mul: accumulator high half / div: partial remainder
    logic [XLEN-1:0]   lo;   // mul: multiplier shifting out / div: dividend -> quotient
    logic [XLEN-1:0]   opa;  // mul: multiplicand magnitude / div: divisor magnitude
    logic              neg;
    logic [2:0]        f3;
    logic [SHW-1:0]    cnt;

    logic              accept, m_op;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   alu_res;

    assign in_ready = !rst && (state == StIdle) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign m_op     = ENABLE_M && m_ext;
    assign busy     = (state != StIdle);
    assign shamt    = op2[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (field)
            4'b0000: alu_res = op1 + op2;
            4'b1000: alu_res = op1 - op2;
            4'b0111: alu_res = op1 & op2;
            4'b0110: alu_res = op1 | op2;
            4'b0100: alu_res = op1 ^ op2;
            4'b0001: alu_res = op1 << shamt;
            4'b0101: alu_res = op1 >> shamt;
            4'b1101: alu_res = XLEN'($signed(op1) >>> shamt);
            4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            4'b0011: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
            default: alu_res = '0;
        endcase
    end

    // Operand signedness by funct3: div ops signed when funct3[0]==0; MULHU unsigned
    // both, MULHSU unsigned op2 only.
    logic            op1_signed, op2_signed, neg1, neg2, sign_in;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, ovf, special;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        op1_signed = field[2] ? !field[0] : (field[1:0] != 2'b11);
        op2_signed = field[2] ? !field[0] : !field[1];
        neg1       = op1_signed && op1[XLEN-1];
        neg2       = op2_signed && op2[XLEN-1];
        mag1       = neg1 ? -op1 : op1;
        mag2       = neg2 ? -op2 : op2;
        sign_in    = (field[2] && field[1]) ? neg1 : (neg1 ^ neg2);
        div_zero   = (op2 == '0);
        ovf        = !field[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
        special    = field[2] && (div_zero || ovf);
        if (div_zero) spec_res = field[1] ? op1 : '1;
        else          spec_res = field[1] ? '0 : op1;
    end

    logic [XLEN:0]     msum, r_sh, diff;
    logic              ge;
    logic [XLEN-1:0]   step_hi, step_lo;

    always_comb begin
        msum = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
        r_sh = {hi, lo[XLEN-1]};
        diff = r_sh - {1'b0, opa};
        ge   = !diff[XLEN];
        if (f3[2]) begin
            step_hi = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
            step_lo = {lo[XLEN-2:0], ge};
        end else begin
            step_hi = msum[XLEN:1];
            step_lo = {msum[0], lo[XLEN-1:1]};
        end
    end

    // The last iteration is folded into StDone together with the sign fix-up.
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   mul_res, div_res, fin_res;

    always_comb begin
        prod    = {step_hi, step_lo};
        prod_s  = neg ? -prod : prod;
        mul_res = (f3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        if (f3[1]) div_res = neg ? -step_hi : step_hi;
        else       div_res = neg ? -step_lo : step_lo;
        fin_res = f3[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            out_valid <= 1'b0;
            result    <= '0;
            hi        <= '0;
            lo        <= '0;
            opa       <= '0;
            neg       <= 1'b0;
            f3        <= '0;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                StIdle: begin
                    if (accept) begin
                        if (m_op && !special) begin
                            state <= field[2] ? StDiv : StMul;
                            hi    <= '0;
                            lo    <= mag1;
                            opa   <= mag2;
                            neg   <= sign_in;
                            f3    <= field[2:0];
                            cnt   <= '0;
                        end else begin
                            result    <= m_op ? spec_res : alu_res;
                            out_valid <= 1'b1;
                        end
                    end
                end
                StMul, StDiv: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(XLEN - 2)) state <= StDone;
                end
                StDone: begin
                    result    <= fin_res;
                    out_valid <= 1'b1;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
